// File: rtl/mem_access_stage.sv
// Memory stage: turns loads/stores into req/ack bus transactions and formats load data for ME_WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being issued.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] mem_data_out,
  output logic        stall_out,
  output logic        bus_err,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // The offset comes from the address latched at accept time, not the live pipeline input.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       mem_data_out_q, mem_data_out_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_trap_q, misalign_trap_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;

  logic              mem_op_s;
  logic              trap_cond_s;
  logic              start_s;
  logic              trap_evt_s;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_cond_s = ((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                       (funct3_in[1] & (addr_in[1:0] != 2'b00));
`else
  assign trap_cond_s = 1'b0;
`endif

  assign mem_op_s   = valid_in & ~flush_in & (mem_read_in | mem_write_in);
  assign start_s    = mem_op_s & ~trap_cond_s;
  assign trap_evt_s = mem_op_s & trap_cond_s;
  assign stall_out  = ((state_q == ST_IDLE) & start_s) | (state_q == ST_WAIT);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus_req_d       = bus_req_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_be_d        = bus_be_q;
    bus_wdata_d     = bus_wdata_q;
    mem_data_out_d  = mem_data_out_q;
    bus_err_d       = 1'b0;
    misalign_trap_d = 1'b0;
    f3_d            = f3_q;
    alo_d           = alo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_in;
          bus_addr_d  = {addr_in[31:2], 2'b00};
          bus_be_d    = lane_be(funct3_in, addr_in[1:0]);
          bus_wdata_d = lane_data(funct3_in, wdata_in);
          f3_d        = funct3_in;
          alo_d       = addr_in[1:0];
        end else if (trap_evt_s) begin
          misalign_trap_d = 1'b1;
          mem_data_out_d  = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_ack) begin
          state_d   = ST_DONE;
          cnt_d     = '0;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            mem_data_out_d = load_format(f3_q, alo_q, bus_rdata);
          end else begin
            mem_data_out_d = mem_data_out_q;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d        = ST_DONE;
          cnt_d          = '0;
          bus_req_d      = 1'b0;
          mem_data_out_d = 32'h0000_0000;
          bus_err_d      = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= 32'h0000_0000;
      bus_be_q        <= 4'b0000;
      bus_wdata_q     <= 32'h0000_0000;
      mem_data_out_q  <= 32'h0000_0000;
      bus_err_q       <= 1'b0;
      misalign_trap_q <= 1'b0;
      f3_q            <= 3'b000;
      alo_q           <= 2'b00;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_be_q        <= bus_be_d;
      bus_wdata_q     <= bus_wdata_d;
      mem_data_out_q  <= mem_data_out_d;
      bus_err_q       <= bus_err_d;
      misalign_trap_q <= misalign_trap_d;
      f3_q            <= f3_d;
      alo_q           <= alo_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign mem_data_out  = mem_data_out_q;
  assign bus_err       = bus_err_q;
  assign misalign_trap = misalign_trap_q;

endmodule
